sync_to_async_tx: RTL and testbench

- Synchronous-to-asynchronous bridge; it is the clocked stage directly upstream of the self-timed pipeline built from the library cells (C-elements, rs_latch_ii, nand/inv).
- Accepts words on a clocked valid/ready interface and buffers them in a small FIFO.
- Issues each word as a 4-phase (return-to-zero) bundled-data transfer: out_req / out_ack, with out_data held stable around out_req.
- out_ack arrives asynchronously and is synchronized internally.

---
 rtl/async_hs_pkg.sv | 13 +
 rtl/sync_chain.sv | 30 +++
 rtl/sync_to_async_tx.sv | 133 +++++++++++++
 tb/tb_sync_to_async_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_hs_pkg.sv
// rtl/async_hs_pkg.sv - shared handshake definitions for the sync/async bridges
package async_hs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_REQ_HI = 2'd2,
        ST_RTZ    = 2'd3
    } hs_state_e;

    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchronizer for a single asynchronous bit
module sync_chain
    import async_hs_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sync_to_async_tx.sv
// rtl/sync_to_async_tx.sv - clocked FIFO feeding a 4-phase bundled-data async stage
module sync_to_async_tx
    import async_hs_pkg::*;
#(
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DW-1:0]            out_data,
    output logic                     out_req,
    input  logic                     out_ack,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]  mem_q [DEPTH];
    logic [AW:0]    wptr_q, wptr_d;
    logic [AW:0]    rptr_q, rptr_d;
    logic [AW:0]    level_w;
    logic           full, empty, push, pop;
    logic [DW-1:0]  head;

    hs_state_e      state_q, state_d;
    logic           out_req_q, out_req_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic           proto_err_q, proto_err_d;
    logic           ack_prev_q, ack_prev_d;
    logic           ack_s;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (out_ack),
        .q    (ack_s)
    );

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign level_w = wptr_q - rptr_q;
    assign full    = (level_w == (AW+1)'(DEPTH));
    assign empty   = (wptr_q == rptr_q);
    assign push    = in_valid && !full;
    assign head    = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(push);
        rptr_d = rptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= in_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_req_d   = out_req_q;
        out_data_d  = out_data_q;
        proto_err_d = proto_err_q;
        ack_prev_d  = ack_s;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ack_s) proto_err_d = 1'b1;
                if (!empty) begin
                    out_data_d = head;
                    pop        = 1'b1;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (ack_s) proto_err_d = 1'b1;
                out_req_d = 1'b1;
                state_d   = ST_REQ_HI;
            end
            ST_REQ_HI: begin
                if (ack_s) begin
                    out_req_d = 1'b0;
                    state_d   = ST_RTZ;
                end
            end
            ST_RTZ: begin
                // A spurious re-rise is flagged but otherwise ignored; we keep waiting for zero.
                if (ack_s && !ack_prev_q) begin
                    proto_err_d = 1'b1;
                end else if (!ack_s) begin
                    if (!empty) begin
                        out_data_d = head;
                        pop        = 1'b1;
                        state_d    = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            state_q     <= ST_IDLE;
            out_req_q   <= 1'b0;
            out_data_q  <= '0;
            proto_err_q <= 1'b0;
            ack_prev_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            state_q     <= state_d;
            out_req_q   <= out_req_d;
            out_data_q  <= out_data_d;
            proto_err_q <= proto_err_d;
            ack_prev_q  <= ack_prev_d;
        end
    end

    assign in_ready  = !full;
    assign out_data  = out_data_q;
    assign out_req   = out_req_q;
    assign level     = level_w;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sync_to_async_tx.sv
// tb/tb_sync_to_async_tx.sv - directed self-checking bench for sync_to_async_tx
module tb_sync_to_async_tx;
    import async_hs_pkg::*;

    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_req;
    logic          out_ack = 1'b0;
    logic [2:0]    level;
    logic          proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    sync_to_async_tx #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_req   (out_req),
        .out_ack   (out_ack),
        .level     (level),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Async-stage model: follows out_req after a programmable number of cycles.
    int resp_on = 0;
    int dmin = 0;
    int dmax = 0;
    int cnt = 0;
    bit pend = 1'b0;

    initial forever begin
        @(posedge clk);
        #2;
        if (!rstn) begin
            out_ack = 1'b0;
            pend = 1'b0;
        end else if (resp_on != 0) begin
            if (out_req !== out_ack) begin
                if (!pend) begin
                    pend = 1'b1;
                    cnt = $urandom_range(dmax, dmin);
                end
                if (cnt == 0) begin
                    out_ack = out_req;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    logic [DW-1:0] rx_q[$];
    logic          prev_req = 1'b0;
    logic          prev_acks = 1'b0;
    logic          prev_rstn = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [2:0]    prev_lvl = '0;
    hs_state_e     prev_st = ST_IDLE;
    int stab_bad = 0;
    int b2b_bad = 0;
    int b2b_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (rstn && prev_rstn) begin
            if (out_req && !prev_req) rx_q.push_back(out_data);
            if (out_data !== prev_data && (prev_req || out_req || prev_acks)) stab_bad++;
            if (prev_st == ST_RTZ && dut.state_q == ST_IDLE && prev_lvl != 0) b2b_bad++;
            if (prev_st == ST_RTZ && dut.state_q == ST_SETUP) b2b_cnt++;
        end
        prev_req  = out_req;
        prev_acks = dut.ack_s;
        prev_rstn = rstn;
        prev_data = out_data;
        prev_lvl  = level;
        prev_st   = dut.state_q;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] d);
        in_data = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_wait(input logic [DW-1:0] d);
        int t = 0;
        while (!in_ready && t < 200) begin
            tick(1);
            t++;
        end
        check("push_wait_ready", in_ready, 1);
        push(d);
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int t = 0;
        while (rx_q.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        check({tag, "_rx_count"}, rx_q.size(), n);
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while ((level != 0 || dut.state_q != ST_IDLE || out_ack) && t < 500) begin
            tick(1);
            t++;
        end
        check({tag, "_drained_level"}, level, 0);
    endtask

    initial begin
        int n;

        // Reset state
        tick(3);
        check("rst_out_req", out_req, 0);
        check("rst_out_data", out_data, 0);
        check("rst_level", level, 0);
        check("rst_proto_err", proto_err, 0);
        rstn = 1'b1;
        tick(1);
        check("rst_in_ready", in_ready, 1);

        // Single word, ack = out_req delayed 3 cycles
        resp_on = 1; dmin = 3; dmax = 3;
        rx_q.delete();
        push(8'hA5);
        check("t1_level_n", level, 1);
        tick(1);
        check("t1_data_n1", out_data, 8'hA5);
        check("t1_req_n1", out_req, 0);
        tick(1);
        check("t1_req_n2", out_req, 1);
        n = 0;
        while (!out_ack && n < 20) begin
            tick(1);
            n++;
        end
        check("t1_ack_rise", out_ack, 1);
        n = 0;
        while (out_req && n < 20) begin
            tick(1);
            n++;
        end
        check("t1_req_fall_lat", n, SS + 1);
        tick(10);
        check("t1_level_end", level, 0);
        check("t1_proto_err", proto_err, 0);
        check("t1_rx_count", rx_q.size(), 1);
        if (rx_q.size() >= 1) check("t1_rx0", rx_q[0], 8'hA5);

        // Burst to full with ack held low
        wait_drain("t2_pre");
        resp_on = 0; out_ack = 1'b0;
        rx_q.delete();
        for (int i = 1; i <= 5; i++) push(8'(i));
        check("t2_level_full", level, 4);
        check("t2_in_ready", in_ready, 0);
        check("t2_out_data", out_data, 8'h01);
        push(8'h06);
        check("t2_refused_level", level, 4);
        check("t2_req_held", out_req, 1);
        check("t2_data_held", out_data, 8'h01);
        resp_on = 1; dmin = 0; dmax = 0;
        wait_rx(5, 300, "t2");
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) check($sformatf("t2_rx%0d", i), rx_q[i], 32'(i + 1));
        end
        wait_drain("t2");

        // Simultaneous push and pop at level 1
        tick(5);
        resp_on = 0; out_ack = 1'b0;
        rx_q.delete();
        push(8'h10);
        push(8'h11);
        check("t3_level_sim", level, 1);
        check("t3_out_data", out_data, 8'h10);
        resp_on = 1; dmin = 1; dmax = 1;
        wait_rx(2, 200, "t3");
        if (rx_q.size() >= 2) begin
            check("t3_rx0", rx_q[0], 8'h10);
            check("t3_rx1", rx_q[1], 8'h11);
        end
        wait_drain("t3");

        // Back-to-back with random ack delay
        dmin = 0; dmax = 5;
        rx_q.delete();
        b2b_cnt = 0;
        for (int i = 0; i < 8; i++) push_wait(8'h20 + 8'(i));
        wait_rx(8, 1500, "t4");
        for (int i = 0; i < 8; i++) begin
            if (i < rx_q.size()) check($sformatf("t4_rx%0d", i), rx_q[i], 32'h20 + 32'(i));
        end
        check("t4_no_idle_gap", b2b_bad, 0);
        check("t4_rtz_to_setup_seen", (b2b_cnt > 0), 1);
        wait_drain("t4");

        // Protocol error: ack pulse while idle
        tick(5);
        resp_on = 0;
        out_ack = 1'b1;
        tick(4);
        out_ack = 1'b0;
        tick(4);
        check("t5_proto_err_set", proto_err, 1);
        tick(5);
        check("t5_proto_err_sticky", proto_err, 1);
        rx_q.delete();
        resp_on = 1; dmin = 1; dmax = 1;
        push(8'h3C);
        wait_rx(1, 200, "t5");
        if (rx_q.size() >= 1) check("t5_rx0", rx_q[0], 8'h3C);
        wait_drain("t5");
        check("t5_proto_err_end", proto_err, 1);

        // Reset in the middle of a handshake
        tick(5);
        resp_on = 0; out_ack = 1'b0;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        check("t6_pre_level", level, 2);
        check("t6_pre_req", out_req, 1);
        check("t6_pre_state", dut.state_q, ST_REQ_HI);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_req", out_req, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_proto_err", proto_err, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick(1);
        rx_q.delete();
        resp_on = 1; dmin = 2; dmax = 2;
        push(8'h77);
        wait_rx(1, 200, "t6");
        if (rx_q.size() >= 1) check("t6_rx0", rx_q[0], 8'h77);
        wait_drain("t6");
        check("t6_proto_err_end", proto_err, 0);

        check("data_stable", stab_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
